// File: rtl/axi4s_demux_tid.sv
// axi4s_demux_tid: routes one AXI4-S stream to one of nr_of_streams_p outputs
// selected by tid. Whole packets are routed by their first beat's tid, and
// packets with an out-of-range tid are swallowed. There is one registered
// output stage with full throughput.
module axi4s_demux_tid #(
  parameter int nr_of_streams_p = -1,
  parameter int tdata_width_p   = -1,
  parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  output logic                                          axi4s_i_tready,
  input  logic                                          axi4s_i_tvalid,
  input  logic                                          axi4s_i_tlast,
  input  logic [tid_bit_width_p-1:0]                    axi4s_i_tid,
  input  logic [tdata_width_p-1:0]                      axi4s_i_tdata,
  input  logic [nr_of_streams_p-1:0]                    axi4s_o_tready,
  output logic [nr_of_streams_p-1:0]                    axi4s_o_tvalid,
  output logic [nr_of_streams_p-1:0]                    axi4s_o_tlast,
  output logic [nr_of_streams_p-1:0][tdata_width_p-1:0] axi4s_o_tdata,
  output logic                                          tid_error
);

  // Destination index width, and a compare width wide enough for any tid.
  localparam int unsigned DW = $clog2(nr_of_streams_p);
  localparam int unsigned CW = 32'(tid_bit_width_p) + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t                   state;
  logic [DW-1:0]            lock_dest;
  logic                     out_valid;
  logic [DW-1:0]            out_dest;
  logic                     out_last;
  logic [tdata_width_p-1:0] out_data;

  logic          acc;
  logic          in_range;
  logic          tid_mismatch;
  logic          deliver;
  logic [DW-1:0] dest_sel;

  // Ready depends only on reset and the downstream ready of the held beat.
  assign axi4s_i_tready = !rst && (!out_valid || axi4s_o_tready[out_dest]);
  assign acc            = axi4s_i_tvalid && axi4s_i_tready;

  // Unsigned range and lock compares, widened so any tid width is safe.
  assign in_range     = CW'(axi4s_i_tid) < CW'(nr_of_streams_p);
  assign tid_mismatch = CW'(axi4s_i_tid) != CW'(lock_dest);

  // A beat reaches the output register unless it belongs to a dropped packet.
  assign deliver  = acc && ((state == IDLE && in_range) || state == LOCKED);
  assign dest_sel = (state == LOCKED) ? lock_dest : DW'(axi4s_i_tid);

  // Routing FSM plus output register; a load wins over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_dest <= '0;
      out_valid <= 1'b0;
      out_dest  <= '0;
      out_last  <= 1'b0;
      out_data  <= '0;
      tid_error <= 1'b0;
    end else begin
      tid_error <= 1'b0;

      if (deliver) begin
        out_valid <= 1'b1;
        out_dest  <= dest_sel;
        out_last  <= axi4s_i_tlast;
        out_data  <= axi4s_i_tdata;
      end else if (out_valid && axi4s_o_tready[out_dest]) begin
        out_valid <= 1'b0;
      end

      if (acc) begin
        case (state)
          IDLE: begin
            if (in_range) begin
              if (!axi4s_i_tlast) begin
                state     <= LOCKED;
                lock_dest <= DW'(axi4s_i_tid);
              end
            end else begin
              tid_error <= 1'b1;
              if (!axi4s_i_tlast) state <= DROP;
            end
          end
          LOCKED: begin
            if (tid_mismatch) tid_error <= 1'b1;
            if (axi4s_i_tlast) state <= IDLE;
          end
          DROP: begin
            if (axi4s_i_tlast) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Valid goes only to the held beat's destination.
  always_comb begin
    axi4s_o_tvalid = '0;
    if (out_valid) axi4s_o_tvalid[out_dest] = 1'b1;
  end

  // Payload and last are broadcast to every output.
  always_comb begin
    for (int k = 0; k < nr_of_streams_p; k++) begin
      axi4s_o_tdata[k] = out_data;
      axi4s_o_tlast[k] = out_last;
    end
  end

endmodule

// File: tb/tb_axi4s_demux_tid.sv
// Scoreboard bench for axi4s_demux_tid with three outputs and 8-bit data.
module tb_axi4s_demux_tid;

  localparam int N = 3;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_tready;
  logic             i_tvalid;
  logic             i_tlast;
  logic [1:0]       i_tid;
  logic [W-1:0]     i_tdata;
  logic [N-1:0]     o_tready;
  logic [N-1:0]     o_tvalid;
  logic [N-1:0]     o_tlast;
  logic [N-1:0][W-1:0] o_tdata;
  logic             tid_error;

  axi4s_demux_tid #(
    .nr_of_streams_p(N),
    .tdata_width_p  (W),
    .tid_bit_width_p(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .axi4s_i_tready(i_tready),
    .axi4s_i_tvalid(i_tvalid),
    .axi4s_i_tlast (i_tlast),
    .axi4s_i_tid   (i_tid),
    .axi4s_i_tdata (i_tdata),
    .axi4s_o_tready(o_tready),
    .axi4s_o_tvalid(o_tvalid),
    .axi4s_o_tlast (o_tlast),
    .axi4s_o_tdata (o_tdata),
    .tid_error     (tid_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         dest;
    logic [W-1:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    xfer_cyc[$];

  int mon_checks = 0, mon_fails = 0;
  int tb_checks  = 0, tb_fails  = 0;
  int cyc = 0, stall_cnt = 0, err_cnt = 0;

  logic [N-1:0]        prev_hold;
  logic [N-1:0][W-1:0] prev_data;
  logic [N-1:0]        prev_last;
  beat_t               b;

  task automatic mchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    mon_checks++;
    if (act !== exp) begin
      mon_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tb_checks++;
    if (act !== exp) begin
      tb_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks AXI hold rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = '0;
      sb.delete();
    end else begin
      cyc++;
      if (!i_tready) stall_cnt++;
      if (tid_error) err_cnt++;
      mchk("onehot_valid", 64'($countones(o_tvalid) <= 1), 64'd1);
      for (int k = 0; k < N; k++) begin
        if (prev_hold[k]) begin
          mchk("hold_valid", 64'(o_tvalid[k]), 64'd1);
          mchk("hold_data", 64'(o_tdata[k]), 64'(prev_data[k]));
          mchk("hold_last", 64'(o_tlast[k]), 64'(prev_last[k]));
        end
        if (o_tvalid[k] && o_tready[k]) begin
          if (sb.size() == 0) begin
            mchk("unexpected_beat_out", 64'(k), 64'hFFFF);
          end else begin
            b = sb.pop_front();
            mchk("beat_dest", 64'(k), 64'(b.dest));
            mchk("beat_data", 64'(o_tdata[k]), 64'(b.data));
            mchk("beat_last", 64'(o_tlast[k]), 64'(b.last));
          end
          xfer_cyc.push_back(cyc);
        end
        prev_hold[k] = o_tvalid[k] && !o_tready[k];
        prev_data[k] = o_tdata[k];
        prev_last[k] = o_tlast[k];
      end
    end
  end

  // Presents one beat, waits for acceptance, records the expected output.
  task automatic send(input logic [1:0] tid, input logic [W-1:0] data, input logic last,
                      input bit deliver, input int dest);
    int n = 0;
    i_tvalid = 1'b1;
    i_tid    = tid;
    i_tdata  = data;
    i_tlast  = last;
    @(negedge clk);
    while (!i_tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!i_tready) tchk("accept_timeout", 64'd0, 64'd1);
    else if (deliver) sb.push_back('{dest, data, last});
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0, s0, x0;

  initial begin
    rst      = 1'b1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tid    = '0;
    i_tdata  = '0;
    o_tready = '1;
    settle(3);
    tchk("rst_tvalid", 64'(o_tvalid), 64'd0);
    tchk("rst_tid_error", 64'(tid_error), 64'd0);
    tchk("rst_tready", 64'(i_tready), 64'd0);
    rst = 1'b0;
    settle(1);
    tchk("tready_after_rst", 64'(i_tready), 64'd1);

    // Single-beat routing, no stall expected.
    s0 = stall_cnt;
    send(2'd2, 8'hA5, 1'b1, 1, 2);
    tchk("single_valid_out2", 64'(o_tvalid), 64'b100);
    send(2'd0, 8'h3C, 1'b1, 1, 0);
    tchk("single_valid_out0", 64'(o_tvalid), 64'b001);
    settle(2);
    tchk("single_no_stall", 64'(stall_cnt - s0), 64'd0);

    // Packet lock: later beats keep the first beat's destination.
    e0 = err_cnt;
    send(2'd1, 8'h10, 1'b0, 1, 1);
    send(2'd3, 8'h11, 1'b0, 1, 1);
    send(2'd1, 8'h12, 1'b1, 1, 1);
    settle(3);
    tchk("lock_err_pulses", 64'(err_cnt - e0), 64'd1);

    // Backpressure: output 1 stalls for 5 cycles under a 4-beat packet.
    s0 = stall_cnt;
    o_tready[1] = 1'b0;
    fork
      begin
        send(2'd1, 8'h01, 1'b0, 1, 1);
        send(2'd1, 8'h02, 1'b0, 1, 1);
        send(2'd1, 8'h03, 1'b0, 1, 1);
        send(2'd1, 8'h04, 1'b1, 1, 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        o_tready[1] = 1'b1;
      end
    join
    settle(3);
    tchk("bp_stall_cycles", 64'(stall_cnt - s0), 64'd4);

    // Out-of-range packet is swallowed, next packet routes normally.
    e0 = err_cnt;
    x0 = xfer_cyc.size();
    send(2'd3, 8'hD0, 1'b0, 0, 0);
    send(2'd3, 8'hD1, 1'b1, 0, 0);
    settle(2);
    tchk("drop_no_output", 64'(xfer_cyc.size() - x0), 64'd0);
    send(2'd2, 8'h77, 1'b1, 1, 2);
    settle(3);
    tchk("drop_err_pulses", 64'(err_cnt - e0), 64'd1);

    // Reset mid-packet with a beat held in the output register.
    o_tready = 3'b110;
    send(2'd0, 8'h11, 1'b0, 1, 0);
    tchk("held_before_rst", 64'(o_tvalid), 64'b001);
    rst = 1'b1;
    #1;
    tchk("tready_in_rst", 64'(i_tready), 64'd0);
    settle(1);
    rst = 1'b0;
    #1;
    tchk("rst_mid_tvalid", 64'(o_tvalid), 64'd0);
    tchk("rst_mid_tready", 64'(i_tready), 64'd1);
    settle(1);
    o_tready = '1;
    send(2'd2, 8'h22, 1'b1, 1, 2);
    settle(3);

    // Back-to-back destination switches with no bubble.
    x0 = xfer_cyc.size();
    send(2'd0, 8'hB0, 1'b1, 1, 0);
    send(2'd1, 8'hB1, 1'b1, 1, 1);
    send(2'd2, 8'hB2, 1'b1, 1, 2);
    send(2'd0, 8'hB3, 1'b1, 1, 0);
    settle(3);
    tchk("b2b_count", 64'(xfer_cyc.size() - x0), 64'd4);
    if (xfer_cyc.size() - x0 == 4)
      for (int i = x0; i < x0 + 3; i++)
        tchk("b2b_no_bubble", 64'(xfer_cyc[i+1] - xfer_cyc[i]), 64'd1);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        n++;
        @(posedge clk);
      end
      #1;
    end
    tchk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             mon_checks + tb_checks, mon_fails + tb_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
